bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Round-robin arbiter that shares the single slave bus among N_MST bus masters.
- Bus transaction: req/addr/data/cmd from the master; one-cycle ack plus read data from the slave.
- Sits between the master instances and the slave; forwards exactly one transaction at a time and routes ack and read data back to the granted master.
- Watchdog terminates transactions the slave never acknowledges and flags an error.

Parameters:
N_MST, 4, number of requesting masters (2..8)
AW, 32, address width
DW, 32, data width
TMO, 255, timeout in cycles of s_req high without s_ack; 0 disables timeout

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
m_req  in  N_MST  per-master request, held until ack observed
m_cmd  in  N_MST  per-master command: 0 = read, 1 = write
m_addr  in  N_MST x AW  per-master address
m_data  in  N_MST x DW  per-master write data
m_ack  out  N_MST  one-cycle ack to the granted master
m_err  out  N_MST  one-cycle timeout flag, coincident with m_ack
m_rdata  out  DW  read data, shared, valid with m_ack
s_req  out  1  request to slave
s_cmd  out  1  command to slave
s_addr  out  AW  address to slave
s_data  out  DW  write data to slave
s_ack  in  1  slave acknowledge
s_rdata  in  DW  slave read data, valid with s_ack
grant  out  N_MST  one-hot current owner, 0 when idle
busy  out  1  high in WAIT and RELEASE

Behaviour:
- Reset (rst high at posedge) forces these values, with rst winning over every other event:
  - s_req, s_cmd, s_addr, s_data, m_ack, m_err, m_rdata, grant and busy = 0.
  - Priority pointer = 0; state = IDLE.
- Reset mid-transaction drops s_req on the next edge. Any late s_ack is ignored.
- States: IDLE, WAIT, RELEASE.
- IDLE, when any m_req is high:
  - Select the first requester k, scanning upward from the pointer with wrap-around.
  - Next edge: grant[k]=1 and busy=1. s_req=1; s_cmd/s_addr/s_data are latched from master k. Timeout counter cleared. Go to WAIT.
  - Latency from m_req to s_req = 1 cycle.
- WAIT:
  - s_req and the latched s_cmd/s_addr/s_data are held stable. Master inputs are not re-sampled.
  - Counter increments each cycle without s_ack.
  - On s_ack:
    - Next edge: s_req=0 and m_ack[k]=1.
    - m_rdata = s_rdata if s_cmd=0; m_rdata unchanged if s_cmd=1.
    - Pointer = (k+1) mod N_MST. Go to RELEASE.
  - Timeout, when TMO != 0, counter == TMO-1 and s_ack is low (s_req has been high exactly TMO cycles):
    - Next edge: s_req=0, m_ack[k]=1, m_err[k]=1, m_rdata all ones.
    - Pointer advances as above. Go to RELEASE.
  - s_ack in the same cycle as the timeout condition: normal ack, no error.
  - m_req[k] dropping during WAIT is a protocol violation. The transaction still completes and ack is still pulsed.
- m_ack and m_err are exactly one cycle wide.
- RELEASE:
  - Waits for m_req[k]=0. Next edge: grant=0, busy=0, go to IDLE.
  - Minimum gap between successive s_req pulses: 2 idle cycles of s_req low (RELEASE, IDLE).
- s_ack outside WAIT is ignored.
- Requests from other masters during WAIT/RELEASE stay pending; there is no queue depth beyond the held m_req.
- Fairness: a master that has just been served has lowest priority at the next arbitration.

Test Plan:
- Single read, N_MST=4:
  - Stimulus: m_req[0]=1, cmd=0, addr 0x10; slave acks 3 cycles after s_req with 0xDEADBEEF.
  - Required: s_req rises 1 cycle after m_req and s_addr=0x10. m_ack[0] pulses 1 cycle with m_rdata=0xDEADBEEF. grant returns to 0 after m_req[0] falls.
- Contention:
  - Stimulus: all four masters request at once from reset and re-raise req after each ack.
  - Required: grant order 0,1,2,3,0. No master is served twice before every other waiting master.
- Write:
  - Stimulus: master 2, cmd=1, data 0xA5A5A5A5; slave returns s_rdata 0x12345678.
  - Required: s_data=0xA5A5A5A5; m_rdata keeps its prior value; m_err=0.
- Timeout, TMO=8:
  - Stimulus: slave never acks.
  - Required: s_req high exactly 8 cycles; then m_ack[k]=m_err[k]=1 for one cycle and m_rdata=0xFFFFFFFF.
- Ack/timeout collision, TMO=8:
  - Stimulus: s_ack asserted in the 8th cycle of s_req.
  - Required: m_ack=1, m_err=0, m_rdata=s_rdata.
- Reset in WAIT:
  - Stimulus: rst high for 1 cycle while s_req=1, then s_ack.
  - Required: all outputs 0 on the next edge; s_ack ignored; the next arbitration starts at master 0.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_rr
// Description : Round-robin arbiter that shares one slave bus among N_MST
//               masters. It forwards one transaction at a time, routes the
//               ack and read data back to the owner, and terminates
//               transactions the slave never acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
    parameter int N_MST = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int TMO   = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MST-1:0]          m_req,
    input  logic [N_MST-1:0]          m_cmd,
    input  logic [N_MST-1:0][AW-1:0]  m_addr,
    input  logic [N_MST-1:0][DW-1:0]  m_data,
    output logic [N_MST-1:0]          m_ack,
    output logic [N_MST-1:0]          m_err,
    output logic [DW-1:0]             m_rdata,
    output logic                      s_req,
    output logic                      s_cmd,
    output logic [AW-1:0]             s_addr,
    output logic [DW-1:0]             s_data,
    input  logic                      s_ack,
    input  logic [DW-1:0]             s_rdata,
    output logic [N_MST-1:0]          grant,
    output logic                      busy
);

    localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;
    // The counter only has to reach TMO-1 before the timeout fires.
    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] c_tmo_last = (TMO > 0) ? CW'(TMO - 1) : '0;
    localparam logic [PW-1:0] c_last_mst = PW'(N_MST - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_own;
    logic [PW-1:0]   w_sel;
    logic [PW-1:0]   w_ptr_nxt;
    logic            w_found;
    logic [CW-1:0]   r_cnt;
    logic            w_tmo;

    // First requester at or after the priority pointer, wrapping around.
    always_comb begin : p_scan
        logic [PW-1:0] idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = '0;
        for (int i = 0; i < N_MST; i++) begin
            idx = PW'((int'(r_ptr) + i) % N_MST);
            if (!w_found && m_req[idx]) begin
                w_found = 1'b1;
                w_sel   = idx;
            end
        end
    end

    // A served master drops to lowest priority for the next arbitration.
    assign w_ptr_nxt = (r_own == c_last_mst) ? '0 : r_own + 1'b1;

    // A simultaneous s_ack wins over the timeout, so it is excluded here.
    assign w_tmo = (TMO != 0) && (r_cnt == c_tmo_last) && !s_ack;

    assign busy = (r_state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_found)          w_state_nxt = ST_WAIT;
            ST_WAIT:    if (s_ack || w_tmo)   w_state_nxt = ST_RELEASE;
            ST_RELEASE: if (!m_req[r_own])    w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus datapath: latch the winner, hold it during WAIT, return ack/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_req   <= 1'b0;
            s_cmd   <= 1'b0;
            s_addr  <= '0;
            s_data  <= '0;
            m_ack   <= '0;
            m_err   <= '0;
            m_rdata <= '0;
            grant   <= '0;
            r_ptr   <= '0;
            r_own   <= '0;
            r_cnt   <= '0;
        end else begin
            m_ack <= '0;
            m_err <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        grant  <= N_MST'(1) << w_sel;
                        s_req  <= 1'b1;
                        s_cmd  <= m_cmd[w_sel];
                        s_addr <= m_addr[w_sel];
                        s_data <= m_data[w_sel];
                        r_own  <= w_sel;
                        r_cnt  <= '0;
                    end
                end
                ST_WAIT: begin
                    if (s_ack) begin
                        s_req <= 1'b0;
                        m_ack <= grant;
                        if (!s_cmd) begin
                            m_rdata <= s_rdata;
                        end
                        r_ptr <= w_ptr_nxt;
                    end else if (w_tmo) begin
                        s_req   <= 1'b0;
                        m_ack   <= grant;
                        m_err   <= grant;
                        m_rdata <= '1;
                        r_ptr   <= w_ptr_nxt;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!m_req[r_own]) begin
                        grant <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter_rr
// Description : Self-checking bench for bus_arbiter_rr (N_MST=4, TMO=8) with
//               directed scenarios and randomized traffic against a
//               behavioural round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        m_req;
    logic [N-1:0]        m_cmd;
    logic [N-1:0][AW-1:0] m_addr;
    logic [N-1:0][DW-1:0] m_data;
    logic [N-1:0]        m_ack;
    logic [N-1:0]        m_err;
    logic [DW-1:0]       m_rdata;
    logic                s_req;
    logic                s_cmd;
    logic [AW-1:0]       s_addr;
    logic [DW-1:0]       s_data;
    logic                s_ack;
    logic [DW-1:0]       s_rdata;
    logic [N-1:0]        grant;
    logic                busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int          exp_ptr   = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(.N_MST(N), .AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_data(m_data),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_data(s_data),
        .s_ack(s_ack), .s_rdata(s_rdata),
        .grant(grant), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester scanning upward from ptr.
    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (ptr + i) % N;
            if (((req >> j) & 4'd1) != 0) return j;
        end
        return 0;
    endfunction

    task automatic model_done(input int k, input bit to, input logic c, input logic [31:0] rd);
        exp_ptr = (k + 1) % N;
        if (to)      exp_rdata = 32'hFFFF_FFFF;
        else if (!c) exp_rdata = rd;
    endtask

    task automatic wait_sreq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Slave acks d cycles after s_req is seen, unless the arbiter gives up first.
    task automatic slave_resp(input int d, input logic [31:0] rd);
        for (int i = 0; i < d; i++) begin
            tick();
            if (s_req !== 1'b1) return;
        end
        s_ack   = 1'b1;
        s_rdata = rd;
        tick();
        s_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_req = '0; m_cmd = '0; m_addr = '0; m_data = '0;
        s_ack = 1'b0; s_rdata = '0;
        tick(); tick();
        n_tests++; if ({s_req, s_cmd, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {s_req, s_cmd, busy}); end
        n_tests++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_tests++; if ({m_ack, m_err} !== 8'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b expected 0", {m_ack, m_err}); end
        n_tests++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", m_rdata); end
        n_tests++; if ({s_addr, s_data} !== 64'h0) begin n_fail++; $display("FAIL reset_sbus: got %h expected 0", {s_addr, s_data}); end
        rst = 1'b0;
        exp_ptr = 0; exp_rdata = '0;
    endtask

    task automatic test_single_read();
        logic [3:0] eg;
        m_cmd[0] = 1'b0; m_addr[0] = 32'h10; m_req = 4'b0001;
        eg = 4'(1 << pick(m_req, exp_ptr));
        tick();
        n_tests++; if (s_req !== 1'b1) begin n_fail++; $display("FAIL read_latency: got s_req=%b expected 1", s_req); end
        n_tests++; if (s_addr !== 32'h10) begin n_fail++; $display("FAIL read_addr: got %h expected 00000010", s_addr); end
        n_tests++; if (grant !== eg || busy !== 1'b1) begin n_fail++; $display("FAIL read_grant: got %b/%b expected %b/1", grant, busy, eg); end
        slave_resp(3, 32'hDEAD_BEEF);
        model_done(0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        n_tests++; if (m_ack !== 4'b0001 || m_err !== 4'b0) begin n_fail++; $display("FAIL read_ack: got %b/%b expected 0001/0000", m_ack, m_err); end
        n_tests++; if (m_rdata !== exp_rdata) begin n_fail++; $display("FAIL read_rdata: got %h expected %h", m_rdata, exp_rdata); end
        n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL read_sreq_drop: got %b expected 0", s_req); end
        m_req = '0;
        tick();
        n_tests++; if (m_ack !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL read_release: got ack=%b grant=%b busy=%b expected 0", m_ack, grant, busy); end
    endtask

    task automatic test_contention();
        int   order[5] = '{0, 1, 2, 3, 0};
        bit   ok;
        int   k;
        logic [31:0] rd;
        rst = 1'b1; m_req = '0; tick(); rst = 1'b0;
        exp_ptr = 0; exp_rdata = '0;
        for (int i = 0; i < N; i++) begin
            m_cmd[i] = 1'b0; m_addr[i] = 32'(i * 32'h100); m_data[i] = $urandom;
        end
        m_req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            k = pick(m_req, exp_ptr);
            wait_sreq(ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL cont_wait: no s_req within bound, round %0d", n); end
            n_tests++; if (grant !== 4'(1 << order[n])) begin n_fail++; $display("FAIL cont_order: round %0d got %b expected %b", n, grant, 4'(1 << order[n])); end
            n_tests++; if (s_addr !== m_addr[order[n]]) begin n_fail++; $display("FAIL cont_addr: got %h expected %h", s_addr, m_addr[order[n]]); end
            rd = $urandom;
            slave_resp(1, rd);
            model_done(k, 1'b0, 1'b0, rd);
            n_tests++; if (m_ack !== 4'(1 << k) || m_rdata !== exp_rdata) begin n_fail++; $display("FAIL cont_ack: got %b/%h expected %b/%h", m_ack, m_rdata, 4'(1 << k), exp_rdata); end
            if (n == 4) m_req = '0;
            else        m_req[k] = 1'b0;
            tick();
            n_tests++; if (s_req !== 1'b0 || grant !== 4'b0) begin n_fail++; $display("FAIL cont_gap: got s_req=%b grant=%b expected 0/0000", s_req, grant); end
            if (n != 4) m_req = 4'b1111;
        end
    endtask

    task automatic test_write();
        bit ok;
        logic [31:0] prior;
        prior = exp_rdata;
        m_cmd[2] = 1'b1; m_data[2] = 32'hA5A5_A5A5; m_addr[2] = 32'h200; m_req = 4'b0100;
        wait_sreq(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL write_wait: no s_req within bound"); end
        n_tests++; if (s_data !== 32'hA5A5_A5A5 || s_cmd !== 1'b1) begin n_fail++; $display("FAIL write_sbus: got %h/%b expected a5a5a5a5/1", s_data, s_cmd); end
        slave_resp(2, 32'h1234_5678);
        model_done(2, 1'b0, 1'b1, 32'h1234_5678);
        n_tests++; if (m_ack !== 4'b0100 || m_err !== 4'b0) begin n_fail++; $display("FAIL write_ack: got %b/%b expected 0100/0000", m_ack, m_err); end
        n_tests++; if (m_rdata !== prior) begin n_fail++; $display("FAIL write_rdata_hold: got %h expected %h", m_rdata, prior); end
        m_req = '0; m_cmd[2] = 1'b0;
        tick();
    endtask

    task automatic test_reset_wait();
        bit ok;
        int k;
        logic [31:0] rd;
        m_cmd[2] = 1'b0; m_req = 4'b0100;
        wait_sreq(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rstw_wait: no s_req within bound"); end
        rst = 1'b1; m_req = '0;
        tick();
        n_tests++; if ({s_req, busy} !== 2'b00 || grant !== 4'b0 || m_ack !== 4'b0 || m_rdata !== 32'h0) begin n_fail++; $display("FAIL rstw_clear: got s_req=%b busy=%b grant=%b ack=%b rdata=%h expected 0", s_req, busy, grant, m_ack, m_rdata); end
        rst = 1'b0; s_ack = 1'b1; s_rdata = 32'hCAFE_F00D;
        tick();
        s_ack = 1'b0;
        n_tests++; if (m_ack !== 4'b0 || m_rdata !== 32'h0 || s_req !== 1'b0) begin n_fail++; $display("FAIL rstw_late_ack: got ack=%b rdata=%h s_req=%b expected 0", m_ack, m_rdata, s_req); end
        exp_ptr = 0; exp_rdata = '0;
        m_req = 4'b1010;
        k = pick(m_req, exp_ptr);
        wait_sreq(ok);
        n_tests++; if (grant !== 4'(1 << k)) begin n_fail++; $display("FAIL rstw_ptr: got %b expected %b", grant, 4'(1 << k)); end
        rd = $urandom;
        slave_resp(0, rd);
        model_done(k, 1'b0, 1'b0, rd);
        n_tests++; if (m_ack !== 4'(1 << k) || m_rdata !== exp_rdata) begin n_fail++; $display("FAIL rstw_ack: got %b/%h expected %b/%h", m_ack, m_rdata, 4'(1 << k), exp_rdata); end
        m_req = '0;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        m_cmd[1] = 1'b0; m_req = 4'b0010;
        wait_sreq(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_wait: no s_req within bound"); end
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_req !== 1'b1) break;
            cnt++;
        end
        model_done(1, 1'b1, 1'b0, '0);
        n_tests++; if (cnt !== TMO) begin n_fail++; $display("FAIL tmo_len: s_req high %0d cycles expected %0d", cnt, TMO); end
        n_tests++; if (m_ack !== 4'b0010 || m_err !== 4'b0010) begin n_fail++; $display("FAIL tmo_flags: got %b/%b expected 0010/0010", m_ack, m_err); end
        n_tests++; if (m_rdata !== exp_rdata) begin n_fail++; $display("FAIL tmo_rdata: got %h expected %h", m_rdata, exp_rdata); end
        m_req = '0;
        tick();
        n_tests++; if (m_ack !== 4'b0 || m_err !== 4'b0) begin n_fail++; $display("FAIL tmo_pulse: got %b/%b expected 0000/0000", m_ack, m_err); end
    endtask

    task automatic test_collision();
        bit ok;
        logic [31:0] rd;
        m_cmd[3] = 1'b0; m_req = 4'b1000;
        wait_sreq(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL coll_wait: no s_req within bound"); end
        rd = $urandom;
        slave_resp(TMO - 1, rd);
        model_done(3, 1'b0, 1'b0, rd);
        n_tests++; if (m_ack !== 4'b1000 || m_err !== 4'b0) begin n_fail++; $display("FAIL coll_flags: got %b/%b expected 1000/0000", m_ack, m_err); end
        n_tests++; if (m_rdata !== exp_rdata) begin n_fail++; $display("FAIL coll_rdata: got %h expected %h", m_rdata, exp_rdata); end
        m_req = '0;
        tick();
    endtask

    task automatic test_random();
        logic [3:0]  pend = '0;
        logic [31:0] a_k, d_k, rd;
        logic        c_k;
        bit          ok, to;
        int          k, d;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_req[i]) begin
                    m_addr[i] = $urandom; m_data[i] = $urandom; m_cmd[i] = 1'($urandom);
                end
            end
            pend  = pend | 4'($urandom_range(1, 15));
            m_req = pend;
            k   = pick(pend, exp_ptr);
            a_k = m_addr[k]; d_k = m_data[k]; c_k = m_cmd[k];
            wait_sreq(ok);
            n_tests++; if (!ok || grant !== 4'(1 << k)) begin n_fail++; $display("FAIL rand_grant: it %0d got %b expected %b", it, grant, 4'(1 << k)); end
            // Scramble master inputs; the latched bus must not follow them.
            for (int i = 0; i < N; i++) begin
                m_addr[i] = $urandom; m_data[i] = $urandom; m_cmd[i] = 1'($urandom);
            end
            d  = $urandom_range(0, 9);
            rd = $urandom;
            to = (d >= TMO);
            slave_resp(d, rd);
            model_done(k, to, c_k, rd);
            n_tests++; if (s_addr !== a_k || s_data !== d_k || s_cmd !== c_k) begin n_fail++; $display("FAIL rand_hold: got %h/%h/%b expected %h/%h/%b", s_addr, s_data, s_cmd, a_k, d_k, c_k); end
            n_tests++; if (m_ack !== 4'(1 << k) || m_err !== (to ? 4'(1 << k) : 4'b0)) begin n_fail++; $display("FAIL rand_flags: it %0d got %b/%b expected %b/%b", it, m_ack, m_err, 4'(1 << k), to ? 4'(1 << k) : 4'b0); end
            n_tests++; if (m_rdata !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata: it %0d got %h expected %h", it, m_rdata, exp_rdata); end
            pend[k] = 1'b0;
            m_req   = pend;
            tick();
            n_tests++; if (m_ack !== 4'b0 || m_err !== 4'b0 || grant !== 4'b0 || s_req !== 1'b0) begin n_fail++; $display("FAIL rand_release: got ack=%b err=%b grant=%b s_req=%b expected 0", m_ack, m_err, grant, s_req); end
        end
        m_req = '0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_reset_wait();
        test_timeout();
        test_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
